// File: rtl/word_loader.sv
// Loads one TERM-delimited word from a byte stream into the input word SRAM,
// truncating at DEPTH characters, and holds it until the matcher acknowledges.
module word_loader #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TERM       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  word_valid,
  output logic [ADDR_WIDTH:0]   word_len,
  output logic                  overflow,
  input  logic                  word_ack
);

  // Count value that means the buffer is full (== DEPTH).
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_COUNT  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, READY} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_inc;
  logic                  accept;
  logic                  is_term;

  assign in_ready  = cs && (state != READY);
  assign accept    = in_valid && in_ready;
  assign is_term   = (in_data == TERM);
  assign count_inc = count + ONE_COUNT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      we         <= 1'b0;
      addr       <= '0;
      din        <= '0;
      word_valid <= 1'b0;
      word_len   <= '0;
      overflow   <= 1'b0;
    end else if (!cs) begin
      we <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          // A TERM here is an empty word and is silently dropped.
          if (accept && !is_term) begin
            we    <= 1'b1;
            addr  <= '0;
            din   <= in_data;
            count <= ONE_COUNT;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            if (is_term) begin
              word_len   <= count;
              word_valid <= 1'b1;
              state      <= READY;
            end else begin
              we    <= 1'b1;
              addr  <= count[ADDR_WIDTH-1:0];
              din   <= in_data;
              count <= count_inc;
              if (count_inc == FULL_COUNT) begin
                state <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          // Buffer full: swallow characters until TERM, flagging truncation.
          if (accept) begin
            if (is_term) begin
              word_len   <= FULL_COUNT;
              word_valid <= 1'b1;
              state      <= READY;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        READY: begin
          if (word_ack) begin
            state      <= IDLE;
            count      <= '0;
            overflow   <= 1'b0;
            word_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_loader.sv
// Self-checking bench for word_loader: table vectors, hand-written corner
// sequences and randomized words compared against a stream-level model.
module tb_word_loader;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam logic [DW-1:0] TERM_V = 8'h00;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic          word_valid;
  logic [AW:0]   word_len;
  logic          overflow;
  logic          word_ack = 1'b0;

  word_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TERM(TERM_V)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .addr(addr), .din(din),
    .word_valid(word_valid), .word_len(word_len), .overflow(overflow),
    .word_ack(word_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit gaps   = 1'b0;

  logic [DW-1:0] stim_q[$];
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_d_q[$];
  int            exp_len;
  bit            exp_ovf;

  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  // SRAM write observer.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: split stream at TERM, ignore empty words, keep first DEPTH chars.
  task automatic model();
    logic [DW-1:0] cur[$];
    bit done = 1'b0;
    cur = {};
    foreach (model_q[i]) begin
      if (!done) begin
        if (model_q[i] == TERM_V) begin
          if (cur.size() > 0) done = 1'b1;
        end else begin
          cur.push_back(model_q[i]);
        end
      end
    end
    exp_ovf = cur.size() > DEPTH;
    exp_len = exp_ovf ? DEPTH : cur.size();
    exp_d_q = {};
    for (int i = 0; i < exp_len; i++) exp_d_q.push_back(cur[i]);
  endtask

  task automatic run_stream(output int cycles);
    int  guard;
    bit  ok;
    cycles = 0;
    foreach (stim_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        word_ack = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cycles++;
      end
      in_valid = 1'b1;
      in_data  = stim_q[i];
      word_ack = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      guard = 0;
      do begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        cycles++;
        guard++;
      end while (!ok && guard < 50);
      if (!ok) chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    word_ack = 1'b0;
  endtask

  task automatic finish_word(input string name, input int len_e, input bit ovf_e, input int hold);
    @(negedge clk);
    chk({name, "_valid"}, word_valid, 1);
    chk({name, "_len"}, word_len, len_e);
    chk({name, "_ovf"}, overflow, ovf_e);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      chk({name, "_hold_ready"}, in_ready, 0);
      chk({name, "_hold_valid"}, word_valid, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    word_ack = 1'b1;
    @(posedge clk); #1;
    word_ack = 1'b0;
    @(negedge clk);
    chk({name, "_ack_valid"}, word_valid, 0);
    chk({name, "_ack_ovf"}, overflow, 0);
    chk({name, "_nwrites"}, wa_q.size(), exp_d_q.size());
    for (int i = 0; i < exp_d_q.size() && i < wa_q.size(); i++) begin
      chk({name, "_waddr"}, wa_q[i], i);
      chk({name, "_wdata"}, wd_q[i], exp_d_q[i]);
    end
    wa_q = {};
    wd_q = {};
    @(posedge clk); #1;
  endtask

  typedef struct {
    int    n_lead;
    string s;
    int    len_e;
    bit    ovf_e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    int n;
    int lead;

    vecs[0] = '{0, "cat", 3, 1'b0};
    vecs[1] = '{2, "a", 1, 1'b0};
    vecs[2] = '{0, "abcdefghijklmnop", 16, 1'b0};
    vecs[3] = '{0, "abcdefghijklmnopq", 16, 1'b1};
    vecs[4] = '{1, "ABCDEFGHIJKLMNOPQRSTU", 16, 1'b1};
    vecs[5] = '{0, "xyzxyzxyzxyzxyz", 15, 1'b0};

    // Reset values.
    #12;
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_len", word_len, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors, streamed back-to-back.
    for (int k = 0; k < 6; k++) begin
      stim_q = {};
      for (int j = 0; j < vecs[k].n_lead; j++) stim_q.push_back(TERM_V);
      for (int j = 0; j < vecs[k].s.len(); j++) stim_q.push_back(vecs[k].s[j]);
      stim_q.push_back(TERM_V);
      model_q = stim_q;
      model();
      run_stream(cyc);
      chk("b2b_cycles", cyc, stim_q.size());
      finish_word($sformatf("vec%0d", k), vecs[k].len_e, vecs[k].ovf_e, (k == 0) ? 10 : 0);
    end

    // cs dropped mid-word with in_valid high, then ack ignored while cs low.
    model_q = {8'h61, 8'h62, 8'h63, TERM_V};
    model();
    stim_q = {8'h61, 8'h62};
    run_stream(cyc);
    cs = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h78;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cs_low_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    cs = 1'b1;
    stim_q = {8'h63, TERM_V};
    run_stream(cyc);
    cs = 1'b0;
    word_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("cs_low_ack_ignored", word_valid, 1);
    cs = 1'b1;
    word_ack = 1'b0;
    finish_word("cs_drop", 3, 1'b0, 0);

    // Asynchronous reset after two bytes.
    stim_q = {8'h72, 8'h73};
    run_stream(cyc);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", we, 0);
    chk("arst_addr", addr, 0);
    chk("arst_din", din, 0);
    chk("arst_valid", word_valid, 0);
    @(negedge clk);
    wa_q = {};
    wd_q = {};
    rst_n = 1'b1;
    @(posedge clk); #1;
    stim_q = {8'h7a, 8'h71, TERM_V};
    model_q = stim_q;
    model();
    run_stream(cyc);
    finish_word("after_rst", 2, 1'b0, 0);

    // Randomized words with bubbles and stray acks outside READY.
    gaps = 1'b1;
    for (int w = 0; w < 30; w++) begin
      n    = $urandom_range(1, 20);
      lead = $urandom_range(0, 2);
      stim_q = {};
      for (int j = 0; j < lead; j++) stim_q.push_back(TERM_V);
      for (int j = 0; j < n; j++) stim_q.push_back(8'($urandom_range(1, 255)));
      stim_q.push_back(TERM_V);
      model_q = stim_q;
      model();
      run_stream(cyc);
      finish_word($sformatf("rnd%0d", w), exp_len, exp_ovf, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
